sd_spi_router: RTL and testbench
================================

Name: sd_spi_router

Overview:
- Generalised SD SPI routing and activity block between the core's SPI master and either the physical SD slot or one of NUM_VSD image-backed virtual SD cards.
- Tracks mount state per virtual drive and selects the lowest-index mounted image; falls back to the physical card when no image is mounted.
- Defers selection changes until a transaction boundary, i.e. host chip select deasserted.
- Generates activity-stretched LED drive for the top level.

Parameters:
- NUM_VSD, 2, number of virtual SD channels (1..8).
- ACT_TIMEOUT, 1000000, clk_sys cycles the activity flag is held after the last line toggle.
- CNT_W, 20, activity counter width; must satisfy 2^CNT_W > ACT_TIMEOUT.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- img_mounted  in  NUM_VSD  one-cycle pulse per channel when an image is (un)mounted.
- img_size_nz  in  NUM_VSD  per channel, 1 = mounted image size nonzero; sampled with img_mounted.
- sdclk  in  1  host SPI clock.
- sdmosi  in  1  host MOSI.
- sdss  in  1  host chip select, active-low.
- sdmiso  out  1  routed MISO to host.
- SD_SCK  out  1  physical card clock.
- SD_MOSI  out  1  physical card MOSI.
- SD_CS  out  1  physical card CS, active-low.
- SD_MISO  in  1  physical card MISO.
- vsd_sck  out  1  shared virtual clock (= sdclk).
- vsd_mosi  out  1  shared virtual MOSI (= sdmosi).
- vsd_ss  out  NUM_VSD  per-channel virtual CS, active-low.
- vsd_miso  in  NUM_VSD  per-channel virtual MISO.
- sel_vsd  out  1  1 = a virtual channel is routed.
- sel_idx  out  3  routed channel index (0 when sel_vsd=0).
- sd_act  out  1  stretched activity flag.
- led_user  out  1  sel_vsd & sd_act.
- led_disk  out  2  {1'b1, ~sel_vsd & sd_act}.

Behaviour:
- Mount register valid[i]: on img_mounted[i], valid[i] <= img_size_nz[i]. Simultaneous pulses on several channels all update in the same cycle.
- Pending selection: pend_vsd = |valid; pend_idx = lowest i with valid[i].
- Commit: sel_vsd/sel_idx <= pending only in cycles where sdss=1. While sdss=0 the current routing is frozen.
  - A mount or unmount mid-transaction takes effect on the first cycle after sdss returns high.
  - Commit latency is 1 cycle from the later of the valid update and sdss high.
- Routing, combinational from registered selection:
  - SD_CS = sel_vsd | sdss; SD_SCK = sdclk & ~SD_CS; SD_MOSI = sdmosi & ~SD_CS.
  - vsd_ss[i] = ~(sel_vsd & sel_idx==i) | sdss.
  - sdmiso = sel_vsd ? vsd_miso[sel_idx] : SD_MISO.
- Activity:
  - Register old_mosi and old_miso, where old_miso samples the routed sdmiso.
  - Counter cnt (CNT_W bits).
  - Each cycle: sd_act <= (cnt < ACT_TIMEOUT); if cnt < ACT_TIMEOUT then cnt <= cnt+1.
  - If old_mosi^sdmosi or old_miso^sdmiso, cnt <= 0; this overrides the increment.
  - The counter saturates at ACT_TIMEOUT and never wraps.
  - sd_act is registered: 1-cycle lag from the counter compare.
- Reset values:
  - valid = 0, sel_vsd = 0, sel_idx = 0, cnt = 0, sd_act = 0, old_mosi = 0, old_miso = 0.
  - First cycle after release: sd_act = 1 for ACT_TIMEOUT cycles (power-on blink).
- Derived outputs in reset: SD_CS = sdss, all vsd_ss = 1, led_user = 0, led_disk = 2'b10.
- Reset asserted mid-transaction: routing returns to the physical card immediately, asynchronously; mount state is lost and the top level re-reports mounts.
- sel_idx values of NUM_VSD and above are unreachable.

Optional Feature:
- Macro: SD_ACT_PER_CH_EN.
- Defined:
  - Adds output act_ch [NUM_VSD:0].
  - Bit 0 is physical-card activity; bit i+1 is virtual channel i activity.
  - Each bit has its own CNT_W counter, cleared only by toggles while that target is routed with CS asserted.
  - Each counter uses the same saturation and registered-flag rules as sd_act.
  - sd_act = |act_ch.
- Undefined:
  - No act_ch port.
  - A single shared counter as in Behaviour.

Test Plan:
- Bench setting: ACT_TIMEOUT=16, NUM_VSD=2.
- Scenario 1: after reset release, hold all SPI lines static → sd_act=1 for 16 cycles then 0; SD_CS follows sdss; vsd_ss=2'b11.
- Scenario 2: pulse img_mounted=2'b10 with img_size_nz=2'b10 while sdss=1 → next cycle sel_vsd=1, sel_idx=1. Drive sdss=0, sdclk toggling → SD_SCK stays 0, vsd_ss=2'b01, sdmiso mirrors vsd_miso[1].
- Scenario 3: with channel 1 selected and sdss=0, mount channel 0 → routing stays on channel 1 until sdss=1; one cycle later sel_idx=0.
- Scenario 4: pulse img_mounted=2'b11 with img_size_nz=2'b00 at the same time → valid=0; after sdss=1 routing returns to physical (sel_vsd=0, led_disk follows sd_act).
- Scenario 5: toggle sdmosi every 10 cycles → sd_act stays 1; stop toggling → sd_act falls exactly 17 cycles after the last toggle. Counter never exceeds 16.
- Scenario 6: assert reset_n=0 mid-transfer with channel 0 selected → SD_CS=sdss=0 and vsd_ss=2'b11 without waiting for a clock edge.

Source files
------------

// File: rtl/sd_spi_router.sv
// sd_spi_router
// Routes the core's SPI master either to the physical SD slot or to one of
// NUM_VSD image-backed virtual SD cards, and produces a stretched activity
// flag plus LED drive for the top level.
//
// Selection policy: the lowest-index channel with a mounted, non-empty image
// wins; with nothing mounted the physical card is used. The selection is only
// allowed to change while the host chip select is deasserted, so a mount or
// unmount never switches targets in the middle of a transaction.
//
// Optional feature macro: SD_ACT_PER_CH_EN
//   When defined, an extra output act_ch[NUM_VSD:0] reports activity per
//   target (bit 0 = physical card, bit i+1 = virtual channel i), each with
//   its own stretch counter, and sd_act becomes the OR of those flags.
//   When undefined, a single shared counter drives sd_act.
module sd_spi_router #(
  parameter int NUM_VSD     = 2,
  parameter int ACT_TIMEOUT = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_VSD-1:0] img_mounted,
  input  logic [NUM_VSD-1:0] img_size_nz,
  input  logic               sdclk,
  input  logic               sdmosi,
  input  logic               sdss,
  output logic               sdmiso,
  output logic               SD_SCK,
  output logic               SD_MOSI,
  output logic               SD_CS,
  input  logic               SD_MISO,
  output logic               vsd_sck,
  output logic               vsd_mosi,
  output logic [NUM_VSD-1:0] vsd_ss,
  input  logic [NUM_VSD-1:0] vsd_miso,
  output logic               sel_vsd,
  output logic [2:0]         sel_idx,
  output logic               sd_act,
`ifdef SD_ACT_PER_CH_EN
  output logic [NUM_VSD:0]   act_ch,
`endif
  output logic               led_user,
  output logic [1:0]         led_disk
);

  // Saturation point of every activity counter, sized to the counter.
  localparam logic [CNT_W-1:0] ACT_MAX = CNT_W'(ACT_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Mount tracking and target selection
  // ---------------------------------------------------------------------------
  logic [NUM_VSD-1:0] valid_q, valid_d;
  logic               pend_vsd;
  logic [2:0]         pend_idx;
  logic               sel_vsd_q;
  logic [2:0]         sel_idx_q;

  // Next mount state: each pulsing channel takes its size-nonzero flag,
  // several channels may update in the same cycle.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < NUM_VSD; i++) begin
      if (img_mounted[i]) valid_d[i] = img_size_nz[i];
    end
  end

  // Pending selection: any mounted image, and the lowest index among them.
  // NOTE: every variable written in this block gets a default first, so no
  // latch is inferred on paths where no channel is valid.
  always_comb begin
    pend_vsd = |valid_q;
    pend_idx = 3'd0;
    for (int i = NUM_VSD - 1; i >= 0; i--) begin
      if (valid_q[i]) pend_idx = 3'(i);
    end
  end

  // Mount register and selection commit; the selection only follows the
  // pending value while the host chip select is high (transaction boundary).
  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge value of the others.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      sel_vsd_q <= 1'b0;
      sel_idx_q <= 3'd0;
    end else begin
      valid_q <= valid_d;
      if (sdss) begin
        sel_vsd_q <= pend_vsd;
        sel_idx_q <= pend_idx;
      end
    end
  end

  assign sel_vsd = sel_vsd_q;
  assign sel_idx = sel_idx_q;

  // ---------------------------------------------------------------------------
  // Routing (combinational from the registered selection, so an asynchronous
  // reset returns the bus to the physical card without a clock edge)
  // ---------------------------------------------------------------------------
  logic vsd_miso_sel;

  assign SD_CS   = sel_vsd_q | sdss;
  assign SD_SCK  = sdclk & ~SD_CS;
  assign SD_MOSI = sdmosi & ~SD_CS;

  assign vsd_sck  = sdclk;
  assign vsd_mosi = sdmosi;

  // Per-channel virtual chip selects; only the routed channel is ever low.
  for (genvar g = 0; g < NUM_VSD; g++) begin : g_vsd_ss
    assign vsd_ss[g] = ~(sel_vsd_q & (sel_idx_q == 3'(g))) | sdss;
  end

  // MISO return path: pick the selected virtual channel's line, or the
  // physical card when no image is routed.
  always_comb begin
    vsd_miso_sel = 1'b0;
    for (int i = 0; i < NUM_VSD; i++) begin
      if (sel_idx_q == 3'(i)) vsd_miso_sel = vsd_miso[i];
    end
  end

  assign sdmiso = sel_vsd_q ? vsd_miso_sel : SD_MISO;

  // ---------------------------------------------------------------------------
  // Activity detection
  // ---------------------------------------------------------------------------
  logic old_mosi_q;
  logic old_miso_q;
  logic toggle;

  // Previous MOSI and routed MISO levels for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_mosi_q <= 1'b0;
      old_miso_q <= 1'b0;
    end else begin
      old_mosi_q <= sdmosi;
      old_miso_q <= sdmiso;
    end
  end

  assign toggle = (old_mosi_q ^ sdmosi) | (old_miso_q ^ sdmiso);

`ifdef SD_ACT_PER_CH_EN
  localparam int NCH = NUM_VSD + 1;

  logic [NCH-1:0]   ch_route;
  logic [CNT_W-1:0] ch_cnt_q [NCH];
  logic [NCH-1:0]   ch_act_q;

  // A target is "live" when it is routed and the host chip select is low;
  // only live targets have their counters cleared by line toggles.
  always_comb begin
    ch_route    = '0;
    ch_route[0] = ~sel_vsd_q & ~sdss;
    for (int i = 0; i < NUM_VSD; i++) begin
      ch_route[i+1] = sel_vsd_q & (sel_idx_q == 3'(i)) & ~sdss;
    end
  end

  // Per-target stretch counters; each saturates at ACT_MAX and its flag
  // lags the compare by one cycle.
  // NOTE: this counter array is a handful of flops, not a RAM, so resetting
  // every entry is cheap and gives the same power-on blink on each target.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) ch_cnt_q[c] <= '0;
      ch_act_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        ch_act_q[c] <= (ch_cnt_q[c] < ACT_MAX);
        if (toggle && ch_route[c]) begin
          ch_cnt_q[c] <= '0;
        end else if (ch_cnt_q[c] < ACT_MAX) begin
          ch_cnt_q[c] <= ch_cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  assign act_ch = ch_act_q;
  assign sd_act = |ch_act_q;
`else
  logic [CNT_W-1:0] cnt_q;
  logic             sd_act_q;

  // Shared stretch counter: any toggle restarts it, otherwise it counts up
  // to ACT_MAX and holds there; the flag is the registered compare.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sd_act_q <= 1'b0;
    end else begin
      sd_act_q <= (cnt_q < ACT_MAX);
      if (toggle) begin
        cnt_q <= '0;
      end else if (cnt_q < ACT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sd_act = sd_act_q;
`endif

  // ---------------------------------------------------------------------------
  // LED drive
  // ---------------------------------------------------------------------------
  assign led_user = sel_vsd_q & sd_act;
  assign led_disk = {1'b1, ~sel_vsd_q & sd_act};

endmodule

// File: tb/tb_sd_spi_router.sv
// Directed bench for sd_spi_router with ACT_TIMEOUT=16, NUM_VSD=2 and a
// deliberately small counter (CNT_W=5) so a wrapping counter would show up
// as sd_act re-asserting within a few dozen cycles.
module tb_sd_spi_router;

  localparam int NUM_VSD     = 2;
  localparam int ACT_TIMEOUT = 16;
  localparam int CNT_W       = 5;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [NUM_VSD-1:0] img_mounted;
  logic [NUM_VSD-1:0] img_size_nz;
  logic               sdclk;
  logic               sdmosi;
  logic               sdss;
  logic               sdmiso;
  logic               SD_SCK;
  logic               SD_MOSI;
  logic               SD_CS;
  logic               SD_MISO;
  logic               vsd_sck;
  logic               vsd_mosi;
  logic [NUM_VSD-1:0] vsd_ss;
  logic [NUM_VSD-1:0] vsd_miso;
  logic               sel_vsd;
  logic [2:0]         sel_idx;
  logic               sd_act;
  logic               led_user;
  logic [1:0]         led_disk;

  int n_checks = 0;
  int n_fails  = 0;

  sd_spi_router #(
    .NUM_VSD     (NUM_VSD),
    .ACT_TIMEOUT (ACT_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .img_mounted (img_mounted),
    .img_size_nz (img_size_nz),
    .sdclk       (sdclk),
    .sdmosi      (sdmosi),
    .sdss        (sdss),
    .sdmiso      (sdmiso),
    .SD_SCK      (SD_SCK),
    .SD_MOSI     (SD_MOSI),
    .SD_CS       (SD_CS),
    .SD_MISO     (SD_MISO),
    .vsd_sck     (vsd_sck),
    .vsd_mosi    (vsd_mosi),
    .vsd_ss      (vsd_ss),
    .vsd_miso    (vsd_miso),
    .sel_vsd     (sel_vsd),
    .sel_idx     (sel_idx),
    .sd_act      (sd_act),
    .led_user    (led_user),
    .led_disk    (led_disk)
  );

  always #5 clk_sys = ~clk_sys;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1 ns after it, well away from either clock edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    img_mounted = '0;
    img_size_nz = '0;
    sdclk       = 1'b0;
    sdmosi      = 1'b0;
    sdss        = 1'b1;
    SD_MISO     = 1'b0;
    vsd_miso    = '0;
    repeat (3) tick();

    // Reset state and derived outputs while held in reset.
    check("rst_sel_vsd",  32'(sel_vsd),  32'd0);
    check("rst_sel_idx",  32'(sel_idx),  32'd0);
    check("rst_sd_act",   32'(sd_act),   32'd0);
    check("rst_sd_cs_hi", 32'(SD_CS),    32'd1);
    check("rst_vsd_ss",   32'(vsd_ss),   32'b11);
    check("rst_led_user", 32'(led_user), 32'd0);
    check("rst_led_disk", 32'(led_disk), 32'b10);
    sdss = 1'b0;
    #1;
    check("rst_sd_cs_lo", 32'(SD_CS),    32'd0);
    check("rst_vsd_ss_lo", 32'(vsd_ss),  32'b11);
    sdss = 1'b1;

    // Scenario 1: power-on blink, 16 cycles high then low.
    tick();
    reset_n = 1'b1;
    #1;
    check("s1_act_before_edge", 32'(sd_act), 32'd0);
    for (int k = 1; k <= ACT_TIMEOUT; k++) begin
      tick();
      check("s1_blink_hi", 32'(sd_act), 32'd1);
    end
    tick();
    check("s1_blink_lo", 32'(sd_act), 32'd0);
    check("s1_led_disk", 32'(led_disk), 32'b10);
    sdss  = 1'b0;
    sdclk = 1'b1;
    #1;
    check("s1_sd_cs_follow", 32'(SD_CS),  32'd0);
    check("s1_sd_sck_pass",  32'(SD_SCK), 32'd1);
    check("s1_vsd_ss",       32'(vsd_ss), 32'b11);
    sdss  = 1'b1;
    sdclk = 1'b0;
    #1;
    check("s1_sd_cs_idle", 32'(SD_CS), 32'd1);

    // Scenario 2: mount channel 1 between transactions.
    tick();
    img_size_nz = 2'b10;
    img_mounted = 2'b10;
    tick();
    img_mounted = 2'b00;
    check("s2_no_commit_yet", 32'(sel_vsd), 32'd0);
    tick();
    check("s2_sel_vsd", 32'(sel_vsd), 32'd1);
    check("s2_sel_idx", 32'(sel_idx), 32'd1);
    sdss     = 1'b0;
    vsd_miso = 2'b10;
    sdmosi   = 1'b1;
    #1;
    check("s2_vsd_ss",     32'(vsd_ss),   32'b01);
    check("s2_sd_cs",      32'(SD_CS),    32'd1);
    check("s2_miso_ch1_1", 32'(sdmiso),   32'd1);
    check("s2_sd_mosi",    32'(SD_MOSI),  32'd0);
    check("s2_vsd_mosi",   32'(vsd_mosi), 32'd1);
    sdclk = 1'b1;
    #1;
    check("s2_sd_sck_off", 32'(SD_SCK),  32'd0);
    check("s2_vsd_sck",    32'(vsd_sck), 32'd1);
    sdclk    = 1'b0;
    vsd_miso = 2'b01;
    #1;
    check("s2_miso_ch1_0", 32'(sdmiso), 32'd0);
    tick();
    tick();
    check("s2_led_user", 32'(led_user), 32'd1);
    check("s2_led_disk", 32'(led_disk), 32'b10);

    // Scenario 3: mount channel 0 mid-transaction; switch waits for sdss.
    img_size_nz = 2'b01;
    img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    tick();
    tick();
    check("s3_frozen_vsd", 32'(sel_vsd), 32'd1);
    check("s3_frozen_idx", 32'(sel_idx), 32'd1);
    check("s3_frozen_ss",  32'(vsd_ss),  32'b01);
    sdss = 1'b1;
    #1;
    check("s3_pre_edge_idx", 32'(sel_idx), 32'd1);
    tick();
    check("s3_commit_idx", 32'(sel_idx), 32'd0);
    check("s3_commit_vsd", 32'(sel_vsd), 32'd1);

    // Scenario 4: simultaneous unmount of both channels mid-transaction.
    sdss        = 1'b0;
    img_size_nz = 2'b00;
    img_mounted = 2'b11;
    tick();
    img_mounted = 2'b00;
    tick();
    check("s4_frozen_vsd", 32'(sel_vsd), 32'd1);
    check("s4_frozen_ss",  32'(vsd_ss),  32'b10);
    sdss = 1'b1;
    tick();
    check("s4_phys_vsd", 32'(sel_vsd), 32'd0);
    check("s4_phys_idx", 32'(sel_idx), 32'd0);
    check("s4_led_user", 32'(led_user), 32'd0);

    // Scenario 5: periodic MOSI toggles keep activity alive.
    for (int n = 0; n < 5; n++) begin
      sdmosi = ~sdmosi;
      for (int k = 0; k < 10; k++) begin
        tick();
        check("s5_keepalive", 32'(sd_act), 32'd1);
      end
    end
    // Final toggle: flag must fall exactly 17 edges after it is seen.
    sdmosi = ~sdmosi;
    for (int k = 1; k <= ACT_TIMEOUT + 1; k++) begin
      tick();
      check("s5_tail_hi", 32'(sd_act), 32'd1);
    end
    check("s5_led_disk_hi", 32'(led_disk), 32'b11);
    tick();
    check("s5_fall",        32'(sd_act),   32'd0);
    check("s5_led_disk_lo", 32'(led_disk), 32'b10);
    // Saturation: a wrapping counter would re-assert within 32 cycles.
    for (int k = 0; k < 40; k++) begin
      tick();
      check("s5_saturate", 32'(sd_act), 32'd0);
    end

    // Scenario 6: asynchronous reset mid-transfer on channel 0.
    img_size_nz = 2'b01;
    img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    tick();
    check("s6_sel_vsd", 32'(sel_vsd), 32'd1);
    check("s6_sel_idx", 32'(sel_idx), 32'd0);
    sdss = 1'b0;
    #1;
    check("s6_vsd_ss_live", 32'(vsd_ss), 32'b10);
    check("s6_sd_cs_live",  32'(SD_CS),  32'd1);
    reset_n = 1'b0;
    #1;
    check("s6_async_sd_cs",  32'(SD_CS),    32'd0);
    check("s6_async_vsd_ss", 32'(vsd_ss),   32'b11);
    check("s6_async_sel",    32'(sel_vsd),  32'd0);
    check("s6_async_act",    32'(sd_act),   32'd0);
    check("s6_async_ledd",   32'(led_disk), 32'b10);
    sdss = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check("s6_mount_lost", 32'(sel_vsd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
